// File: rtl/apb_kyber_mailbox_if.sv
// APB3 slave-side bundle for the Kyber mailbox slot.
// master drives the request, slave returns data/ready/error.
interface apb_kyber_mailbox_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_kyber_mailbox.sv
// APB3 mailbox between MSS software and the Kyber accelerator: CSRs, TX/RX FIFOs.
// Optional interrupt block (IRQ_EN/IRQ_STAT, irq port) enabled by KYBER_MBOX_IRQ_EN.
module apb_kyber_mailbox #(
    parameter int DEPTH      = 16,
    parameter int RD_TIMEOUT = 64
) (
    input  logic        PCLK,
    input  logic        PRESET,
    apb_kyber_mailbox_if.slave bus,
    output logic [31:0] tx_tdata,
    output logic        tx_tvalid,
    input  logic        tx_tready,
    input  logic [31:0] rx_tdata,
    input  logic        rx_tvalid,
    output logic        rx_tready,
    output logic        acc_start,
    input  logic        acc_busy,
    input  logic        acc_done
`ifdef KYBER_MBOX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t      state;
    logic [7:0]  wait_cnt;

    logic [31:0] tx_mem [DEPTH];
    logic [31:0] rx_mem [DEPTH];
    logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [LW-1:0] tx_level, rx_level;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic        done_sticky;

    logic [5:0]  off;
    logic        sel_ctrl, sel_stat, sel_txd, sel_rxd;
    logic        sel_ien, sel_ist, mapped;
    logic        access, rd_rx, complete, wr_done;
    logic        pready, timeout;
    logic        tx_push, tx_pop, tx_flush;
    logic        rx_push, rx_pop, rx_flush;
    logic [31:0] status, rdata;
    logic [2:0]  irq_en_q, irq_stat;
    logic        unused_ok;

    assign unused_ok = ^{bus.PADDR[31:8], bus.PADDR[1:0]};

    assign off      = bus.PADDR[7:2];
    assign sel_ctrl = (off == 6'h00);
    assign sel_stat = (off == 6'h01);
    assign sel_txd  = (off == 6'h02);
    assign sel_rxd  = (off == 6'h03);
`ifdef KYBER_MBOX_IRQ_EN
    assign sel_ien  = (off == 6'h04);
    assign sel_ist  = (off == 6'h05);
`else
    assign sel_ien  = 1'b0;
    assign sel_ist  = 1'b0;
`endif
    assign mapped = sel_ctrl | sel_stat | sel_txd | sel_rxd
                  | sel_ien | sel_ist;

    assign tx_full  = (tx_level == LW'(DEPTH));
    assign tx_empty = (tx_level == '0);
    assign rx_full  = (rx_level == LW'(DEPTH));
    assign rx_empty = (rx_level == '0);

    assign access = bus.PSEL & bus.PENABLE;
    assign rd_rx  = access & ~bus.PWRITE & sel_rxd;

    // Wait-state insertion: only an RXDATA read on an empty FIFO stalls.
    always_comb begin
        pready  = 1'b1;
        timeout = 1'b0;
        if (rd_rx && rx_empty) begin
            if (state == S_WAIT && wait_cnt == 8'(RD_TIMEOUT))
                timeout = 1'b1;
            else
                pready = 1'b0;
        end
    end

    assign complete = access & pready;
    assign wr_done  = complete & bus.PWRITE;

    assign bus.PREADY  = pready;
    assign bus.PSLVERR = complete & (~mapped | timeout
                       | (bus.PWRITE & sel_txd & tx_full));

    assign tx_push  = wr_done & sel_txd & ~tx_full;
    assign tx_pop   = tx_tvalid & tx_tready;
    assign tx_flush = wr_done & sel_ctrl & bus.PWDATA[1];
    assign rx_push  = rx_tvalid & rx_tready;
    assign rx_pop   = complete & rd_rx & ~rx_empty;
    assign rx_flush = wr_done & sel_ctrl & bus.PWDATA[2];

    assign tx_tvalid = ~tx_empty;
    assign tx_tdata  = tx_mem[tx_rp];
    assign rx_tready = ~PRESET & ~rx_full;

`ifdef KYBER_MBOX_IRQ_EN
    assign irq_stat = irq_en_q & {tx_empty, ~rx_empty, done_sticky};
`else
    assign irq_en_q = 3'b000;
    assign irq_stat = 3'b000;
`endif

    // STATUS word assembly.
    always_comb begin
        status        = '0;
        status[0]     = tx_full;
        status[1]     = tx_empty;
        status[2]     = rx_full;
        status[3]     = rx_empty;
        status[4]     = acc_busy;
        status[5]     = done_sticky;
        status[15:8]  = 8'(tx_level);
        status[23:16] = 8'(rx_level);
    end

    // Read mux, driven only during a read access phase.
    always_comb begin
        rdata = '0;
        if (access && !bus.PWRITE) begin
            unique case (1'b1)
                sel_stat: rdata = status;
                sel_rxd:  rdata = rx_empty ? 32'h0 : rx_mem[rx_rp];
                sel_ien:  rdata = {29'h0, irq_en_q};
                sel_ist:  rdata = {29'h0, irq_stat};
                default:  rdata = '0;
            endcase
        end
    end
    assign bus.PRDATA = rdata;

    // RXDATA wait-state FSM with timeout counter.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (rd_rx && !pready) begin
                        state    <= S_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                S_WAIT: begin
                    if (pready) begin
                        state    <= S_IDLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    // FIFO storage; contents need no reset.
    always_ff @(posedge PCLK) begin
        if (!PRESET && tx_push) tx_mem[tx_wp] <= bus.PWDATA;
        if (!PRESET && rx_push) rx_mem[rx_wp] <= rx_tdata;
    end

    // TX pointers and level; flush wins over push/pop.
    always_ff @(posedge PCLK) begin
        if (PRESET || tx_flush) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_level <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            if (tx_push && !tx_pop)      tx_level <= tx_level + 1'b1;
            else if (tx_pop && !tx_push) tx_level <= tx_level - 1'b1;
        end
    end

    // RX pointers and level; flush wins over push/pop.
    always_ff @(posedge PCLK) begin
        if (PRESET || rx_flush) begin
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_level <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            if (rx_push && !rx_pop)      rx_level <= rx_level + 1'b1;
            else if (rx_pop && !rx_push) rx_level <= rx_level - 1'b1;
        end
    end

    // Start pulse and done flag; a done pulse beats a same-cycle clear.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            acc_start   <= 1'b0;
            done_sticky <= 1'b0;
        end else begin
            acc_start <= wr_done & sel_ctrl & bus.PWDATA[0] & ~acc_busy;
            if (acc_done)
                done_sticky <= 1'b1;
            else if (wr_done && sel_stat && bus.PWDATA[5])
                done_sticky <= 1'b0;
        end
    end

`ifdef KYBER_MBOX_IRQ_EN
    // Interrupt enable register and registered interrupt line.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            irq_en_q <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_done && sel_ien) irq_en_q <= bus.PWDATA[2:0];
            irq <= |irq_stat;
        end
    end
`endif

endmodule

// File: tb/tb_apb_kyber_mailbox.sv
// Directed self-checking bench for apb_kyber_mailbox.
// Irq checks are built only when KYBER_MBOX_IRQ_EN is defined.
module tb_apb_kyber_mailbox;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tx_tdata;
    logic        tx_tvalid;
    logic        tx_tready;
    logic [31:0] rx_tdata;
    logic        rx_tvalid;
    logic        rx_tready;
    logic        acc_start;
    logic        acc_busy;
    logic        acc_done;
`ifdef KYBER_MBOX_IRQ_EN
    logic        irq;
`endif

    int n_chk = 0;
    int n_err = 0;

    apb_kyber_mailbox_if bus ();

    apb_kyber_mailbox dut (
        .PCLK      (clk),
        .PRESET    (rst),
        .bus       (bus.slave),
        .tx_tdata  (tx_tdata),
        .tx_tvalid (tx_tvalid),
        .tx_tready (tx_tready),
        .rx_tdata  (rx_tdata),
        .rx_tvalid (rx_tvalid),
        .rx_tready (rx_tready),
        .acc_start (acc_start),
        .acc_busy  (acc_busy),
        .acc_done  (acc_done)
`ifdef KYBER_MBOX_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata,
                            output logic [31:0] rdata,
                            output logic err, output int waits);
        @(negedge clk);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = addr;
        bus.PWDATA  = wdata;
        @(negedge clk);
        bus.PENABLE = 1'b1;
        waits = 0;
        #1;
        while (!bus.PREADY && waits < 300) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!bus.PREADY) chk("pready_bound", 32'(bus.PREADY), 32'h1);
        rdata = bus.PRDATA;
        err   = bus.PSLVERR;
        @(negedge clk);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          wt;
    int          got_n;
    int          cyc;

    initial begin
        rst = 1'b1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0;  bus.PWDATA = '0;
        tx_tready = 1'b0; rx_tdata = '0; rx_tvalid = 1'b0;
        acc_busy = 1'b0;  acc_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rx_tready", 32'(rx_tready), 32'h0);
        chk("rst_pready", 32'(bus.PREADY), 32'h1);
        chk("rst_prdata", bus.PRDATA, 32'h0);
        rst = 1'b0;
        #1;
        chk("rst_tx_tvalid", 32'(tx_tvalid), 32'h0);
        chk("rst_acc_start", 32'(acc_start), 32'h0);

        apb_xfer(1'b0, 32'h04, 0, rd, er, wt);
        chk("rst_status", rd, 32'h0000_000A);
        chk("rst_status_err", 32'(er), 32'h0);
        chk("rst_status_waits", 32'(wt), 32'h0);

        apb_xfer(1'b0, 32'h40, 0, rd, er, wt);
        chk("unmap_rd_data", rd, 32'h0);
        chk("unmap_rd_err", 32'(er), 32'h1);
        apb_xfer(1'b1, 32'h40, 32'h7, rd, er, wt);
        chk("unmap_wr_err", 32'(er), 32'h1);
`ifndef KYBER_MBOX_IRQ_EN
        apb_xfer(1'b0, 32'h10, 0, rd, er, wt);
        chk("irqen_unmapped_err", 32'(er), 32'h1);
`endif

        for (int i = 0; i < 16; i++) begin
            apb_xfer(1'b1, 32'h08, 32'h1000_0000 + i, rd, er, wt);
            chk("tx_push_err", 32'(er), 32'h0);
        end
        apb_xfer(1'b1, 32'h08, 32'hDEAD_BEEF, rd, er, wt);
        chk("tx_overflow_err", 32'(er), 32'h1);
        apb_xfer(1'b0, 32'h04, 0, rd, er, wt);
        chk("tx_full_status", rd, 32'h0000_1009);

        @(negedge clk);
        tx_tready = 1'b1;
        got_n = 0;
        cyc = 0;
        while (got_n < 16 && cyc < 40) begin
            #1;
            if (tx_tvalid) begin
                chk("tx_drain_data", tx_tdata, 32'h1000_0000 + got_n);
                got_n++;
            end
            @(negedge clk);
            cyc++;
        end
        #1;
        chk("tx_drain_count", 32'(got_n), 32'd16);
        chk("tx_drain_empty", 32'(tx_tvalid), 32'h0);
        tx_tready = 1'b0;

        for (int i = 0; i < 3; i++)
            apb_xfer(1'b1, 32'h08, 32'h55 + i, rd, er, wt);
        apb_xfer(1'b0, 32'h04, 0, rd, er, wt);
        chk("tx_pre_flush", rd, 32'h0000_0308);
        apb_xfer(1'b1, 32'h00, 32'h2, rd, er, wt);
        apb_xfer(1'b0, 32'h04, 0, rd, er, wt);
        chk("tx_post_flush", rd, 32'h0000_000A);

        @(negedge clk);
        rx_tvalid = 1'b1; rx_tdata = 32'hA1A1_0001;
        @(negedge clk);
        rx_tdata = 32'hB2B2_0002;
        @(negedge clk);
        rx_tvalid = 1'b0;
        apb_xfer(1'b0, 32'h04, 0, rd, er, wt);
        chk("rx_two_status", rd, 32'h0002_0002);
        apb_xfer(1'b0, 32'h0C, 0, rd, er, wt);
        chk("rx_pop0_data", rd, 32'hA1A1_0001);
        chk("rx_pop0_waits", 32'(wt), 32'h0);
        apb_xfer(1'b0, 32'h0C, 0, rd, er, wt);
        chk("rx_pop1_data", rd, 32'hB2B2_0002);

        fork
            apb_xfer(1'b0, 32'h0C, 0, rd, er, wt);
            begin
                repeat (6) @(negedge clk);
                rx_tdata  = 32'hCAFE_F00D;
                rx_tvalid = 1'b1;
                @(negedge clk);
                rx_tvalid = 1'b0;
            end
        join
        chk("rx_wait_data", rd, 32'hCAFE_F00D);
        chk("rx_wait_err", 32'(er), 32'h0);
        chk("rx_wait_states", 32'(wt), 32'd5);

        apb_xfer(1'b0, 32'h0C, 0, rd, er, wt);
        chk("rx_tmo_waits", 32'(wt), 32'd64);
        chk("rx_tmo_err", 32'(er), 32'h1);
        chk("rx_tmo_data", rd, 32'h0);
        apb_xfer(1'b0, 32'h04, 0, rd, er, wt);
        chk("rx_tmo_status", rd, 32'h0000_000A);

        apb_xfer(1'b1, 32'h00, 32'h1, rd, er, wt);
        #1;
        chk("start_pulse_hi", 32'(acc_start), 32'h1);
        @(negedge clk);
        #1;
        chk("start_pulse_lo", 32'(acc_start), 32'h0);

        acc_busy = 1'b1;
        apb_xfer(1'b1, 32'h00, 32'h1, rd, er, wt);
        chk("start_busy_err", 32'(er), 32'h0);
        #1;
        chk("start_busy_nopulse", 32'(acc_start), 32'h0);
        apb_xfer(1'b0, 32'h04, 0, rd, er, wt);
        chk("status_busy", rd, 32'h0000_001A);
        acc_busy = 1'b0;

        @(negedge clk);
        acc_done = 1'b1;
        @(negedge clk);
        acc_done = 1'b0;
        apb_xfer(1'b0, 32'h04, 0, rd, er, wt);
        chk("done_sticky_set", rd, 32'h0000_002A);

        fork
            apb_xfer(1'b1, 32'h04, 32'h20, rd, er, wt);
            begin
                repeat (2) @(negedge clk);
                acc_done = 1'b1;
                @(negedge clk);
                acc_done = 1'b0;
            end
        join
        apb_xfer(1'b0, 32'h04, 0, rd, er, wt);
        chk("done_set_beats_clr", rd, 32'h0000_002A);

        apb_xfer(1'b1, 32'h04, 32'h20, rd, er, wt);
        apb_xfer(1'b0, 32'h04, 0, rd, er, wt);
        chk("done_cleared", rd, 32'h0000_000A);

`ifdef KYBER_MBOX_IRQ_EN
        apb_xfer(1'b1, 32'h10, 32'h1, rd, er, wt);
        chk("irq_en_wr_err", 32'(er), 32'h0);
        apb_xfer(1'b0, 32'h10, 0, rd, er, wt);
        chk("irq_en_rd", rd, 32'h1);
        #1;
        chk("irq_idle", 32'(irq), 32'h0);
        @(negedge clk);
        acc_done = 1'b1;
        @(negedge clk);
        acc_done = 1'b0;
        #1;
        chk("irq_latency", 32'(irq), 32'h0);
        @(negedge clk);
        #1;
        chk("irq_set", 32'(irq), 32'h1);
        apb_xfer(1'b0, 32'h14, 0, rd, er, wt);
        chk("irq_stat", rd, 32'h1);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
